// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the R/Y/G lamp interface: decodes lamp phase, tracks the
// RED->GREEN->YELLOW cycle, enforces dwell limits and latches the first fault cause.
module traffic_light_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned MIN_RED    = 2,
    parameter int unsigned MIN_GREEN  = 2,
    parameter int unsigned MIN_YELLOW = 1,
    parameter int unsigned MAX_YELLOW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             R,
    input  logic             Y,
    input  logic             G,
    input  logic             clr_fault,
    output logic [1:0]       phase,
    output logic             phase_chg,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] dwell,
    output logic [CYC_W-1:0] cyc_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RED,
        ST_GREEN,
        ST_YELLOW,
        ST_FAULT
    } state_t;

    typedef enum logic [2:0] {
        LMP_DARK,
        LMP_RED,
        LMP_GRN,
        LMP_YEL,
        LMP_ILL
    } lamp_t;

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_RED    = 2'd1;
    localparam logic [1:0] PH_GREEN  = 2'd2;
    localparam logic [1:0] PH_YELLOW = 2'd3;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_ILLEGAL = 3'd1;
    localparam logic [2:0] FC_DARK    = 3'd2;
    localparam logic [2:0] FC_SEQ     = 3'd3;
    localparam logic [2:0] FC_SHORT   = 3'd4;
    localparam logic [2:0] FC_LONG    = 3'd5;

    // Input sample stage; clr_fault rides alongside so every output sees a 2-edge latency.
    logic [2:0]       lamps_q;
    logic             clr_q;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic             chg_q, chg_d;
    logic [2:0]       code_q, code_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;

    lamp_t            lamp;
    lamp_t            cur_lamp;
    lamp_t            succ_lamp;
    state_t           succ_state;
    logic [1:0]       succ_phase;
    int unsigned      min_hold;
    logic [CNT_W-1:0] dwell_inc;
    logic [2:0]       cause;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lamps_q <= '0;
            clr_q   <= 1'b0;
        end else begin
            lamps_q <= {R, Y, G};
            clr_q   <= clr_fault;
        end
    end

    always_comb begin
        lamp = LMP_ILL;
        case (lamps_q)
            3'b100:  lamp = LMP_RED;
            3'b010:  lamp = LMP_YEL;
            3'b001:  lamp = LMP_GRN;
            3'b000:  lamp = LMP_DARK;
            default: lamp = LMP_ILL;
        endcase
    end

    always_comb begin
        cur_lamp   = LMP_DARK;
        succ_lamp  = LMP_DARK;
        succ_state = ST_IDLE;
        succ_phase = PH_IDLE;
        min_hold   = 0;
        case (state_q)
            ST_RED: begin
                cur_lamp   = LMP_RED;
                succ_lamp  = LMP_GRN;
                succ_state = ST_GREEN;
                succ_phase = PH_GREEN;
                min_hold   = MIN_RED;
            end
            ST_GREEN: begin
                cur_lamp   = LMP_GRN;
                succ_lamp  = LMP_YEL;
                succ_state = ST_YELLOW;
                succ_phase = PH_YELLOW;
                min_hold   = MIN_GREEN;
            end
            ST_YELLOW: begin
                cur_lamp   = LMP_YEL;
                succ_lamp  = LMP_RED;
                succ_state = ST_RED;
                succ_phase = PH_RED;
                min_hold   = MIN_YELLOW;
            end
            default: ;
        endcase
    end

    assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        chg_d   = 1'b0;
        code_d  = code_q;
        dwell_d = dwell_q;
        cyc_d   = cyc_q;
        cause   = FC_NONE;

        if (clr_q) begin
            state_d = ST_IDLE;
            phase_d = PH_IDLE;
            code_d  = FC_NONE;
            dwell_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lamp == LMP_RED) begin
                        state_d = ST_RED;
                        phase_d = PH_RED;
                        dwell_d = CNT_W'(1);
                    end
                end
                ST_RED, ST_GREEN, ST_YELLOW: begin
                    if (lamp == cur_lamp) begin
                        if (state_q == ST_YELLOW && 32'(dwell_inc) == MAX_YELLOW + 1)
                            cause = FC_LONG;
                        else
                            dwell_d = dwell_inc;
                    end else if (lamp == succ_lamp) begin
                        if (32'(dwell_q) < min_hold) begin
                            cause = FC_SHORT;
                        end else begin
                            state_d = succ_state;
                            phase_d = succ_phase;
                            dwell_d = CNT_W'(1);
                            chg_d   = 1'b1;
                            if (state_q == ST_YELLOW)
                                cyc_d = cyc_q + CYC_W'(1);
                        end
                    end else if (lamp == LMP_ILL) begin
                        cause = FC_ILLEGAL;
                    end else if (lamp == LMP_DARK) begin
                        cause = FC_DARK;
                    end else begin
                        cause = FC_SEQ;
                    end

                    // Phase and dwell are left untouched on a fault so they freeze at detection.
                    if (cause != FC_NONE) begin
                        state_d = ST_FAULT;
                        code_d  = cause;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_IDLE;
            chg_q   <= 1'b0;
            code_q  <= FC_NONE;
            dwell_q <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            chg_q   <= chg_d;
            code_q  <= code_d;
            dwell_q <= dwell_d;
            cyc_q   <= cyc_d;
        end
    end

    assign phase      = phase_q;
    assign phase_chg  = chg_q;
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = code_q;
    assign dwell      = dwell_q;
    assign cyc_cnt    = cyc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed lamp vectors push expected
// output snapshots; a monitor pops and compares them two edges after issue.
module tb_traffic_light_monitor;

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;
    localparam logic [2:0] LD = 3'b000;

    logic       clk = 1'b0;
    logic       reset;
    logic       R, Y, G, clr_fault;
    logic [1:0] phase;
    logic       phase_chg;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] dwell;
    logic [1:0] cyc_cnt;

    traffic_light_monitor #(
        .CNT_W(8),
        .CYC_W(2),
        .MIN_RED(2),
        .MIN_GREEN(2),
        .MIN_YELLOW(1),
        .MAX_YELLOW(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .R(R),
        .Y(Y),
        .G(G),
        .clr_fault(clr_fault),
        .phase(phase),
        .phase_chg(phase_chg),
        .fault(fault),
        .fault_code(fault_code),
        .dwell(dwell),
        .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    logic [16:0] act;
    assign act = {phase, phase_chg, fault, fault_code, dwell, cyc_cnt};

    int          n_chk = 0;
    int          n_fail = 0;
    int          mon_cyc = 0;
    logic [1:0]  exp_cyc = 2'd0;
    string       cur_tag = "init";

    int          dueq[$];
    logic [16:0] valq[$];
    string       tagq[$];

    int          m_due;
    logic [16:0] m_exp;
    string       m_tag;

    task automatic report(input string t, input logic [16:0] e);
        $display("FAIL %s: got ph=%0d chg=%0b flt=%0b code=%0d dwell=%0d cyc=%0d, expected ph=%0d chg=%0b flt=%0b code=%0d dwell=%0d cyc=%0d",
                 t, act[16:15], act[14], act[13], act[12:10], act[9:2], act[1:0],
                 e[16:15], e[14], e[13], e[12:10], e[9:2], e[1:0]);
    endtask

    task automatic drive(input logic [2:0] lamp, input logic clr);
        @(negedge clk);
        {R, Y, G} = lamp;
        clr_fault = clr;
    endtask

    task automatic st(input logic [2:0] lamp, input logic clr);
        drive(lamp, clr);
    endtask

    task automatic ck(input logic [2:0] lamp, input logic clr, input logic [1:0] ph,
                      input logic chg, input logic flt, input logic [2:0] code,
                      input logic [7:0] dw);
        drive(lamp, clr);
        dueq.push_back(mon_cyc + 2);
        valq.push_back({ph, chg, flt, code, dw, exp_cyc});
        tagq.push_back(cur_tag);
    endtask

    task automatic chk_now(input string t, input logic [16:0] e);
        n_chk++;
        if (act !== e) begin
            n_fail++;
            report(t, e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            while (dueq.size() > 0 && dueq[0] <= mon_cyc) begin
                m_due = dueq.pop_front();
                m_exp = valq.pop_front();
                m_tag = tagq.pop_front();
                n_chk++;
                if (m_due != mon_cyc) begin
                    n_fail++;
                    $display("FAIL %s: check due cycle %0d evaluated at %0d", m_tag, m_due, mon_cyc);
                end else if (act !== m_exp) begin
                    n_fail++;
                    report(m_tag, m_exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        {R, Y, G} = LD;
        clr_fault = 1'b0;
        #1 reset = 1'b0;
        #2 chk_now("reset_init", 17'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        cur_tag = "idle_ignore";
        ck(LD, 0, 0, 0, 0, 0, 0);
        ck(LG, 0, 0, 0, 0, 0, 0);
        ck(LY, 0, 0, 0, 0, 0, 0);
        ck(3'b111, 0, 0, 0, 0, 0, 0);

        cur_tag = "legal_cycle";
        ck(LR, 0, 1, 0, 0, 0, 1);
        ck(LR, 0, 1, 0, 0, 0, 2);
        ck(LR, 0, 1, 0, 0, 0, 3);
        ck(LR, 0, 1, 0, 0, 0, 4);
        ck(LG, 0, 2, 1, 0, 0, 1);
        for (int i = 2; i <= 5; i++) ck(LG, 0, 2, 0, 0, 0, 8'(i));
        ck(LY, 0, 3, 1, 0, 0, 1);
        ck(LY, 0, 3, 0, 0, 0, 2);
        ck(LY, 0, 3, 0, 0, 0, 3);
        exp_cyc = exp_cyc + 2'd1;
        ck(LR, 0, 1, 1, 0, 0, 1);
        ck(LR, 0, 1, 0, 0, 0, 2);

        cur_tag = "bad_sequence";
        ck(LR, 0, 1, 0, 0, 0, 3);
        ck(LR, 0, 1, 0, 0, 0, 4);
        ck(LG, 0, 2, 1, 0, 0, 1);
        for (int i = 2; i <= 5; i++) ck(LG, 0, 2, 0, 0, 0, 8'(i));
        ck(LR, 0, 2, 0, 1, 3, 5);
        ck(LY, 0, 2, 0, 1, 3, 5);
        ck(LD, 1, 0, 0, 0, 0, 0);
        ck(LD, 0, 0, 0, 0, 0, 0);

        cur_tag = "illegal_combo";
        ck(LR, 0, 1, 0, 0, 0, 1);
        ck(LR, 0, 1, 0, 0, 0, 2);
        ck(LR, 0, 1, 0, 0, 0, 3);
        ck(3'b101, 0, 1, 0, 1, 1, 3);
        ck(LR, 1, 0, 0, 0, 0, 0);
        ck(LR, 0, 1, 0, 0, 0, 1);
        ck(LR, 0, 1, 0, 0, 0, 2);
        cur_tag = "clr_overrides";
        ck(3'b111, 1, 0, 0, 0, 0, 0);

        cur_tag = "dark_fault";
        ck(LR, 0, 1, 0, 0, 0, 1);
        ck(LR, 0, 1, 0, 0, 0, 2);
        ck(LD, 0, 1, 0, 1, 2, 2);
        ck(LD, 1, 0, 0, 0, 0, 0);

        cur_tag = "short_green";
        ck(LR, 0, 1, 0, 0, 0, 1);
        ck(LR, 0, 1, 0, 0, 0, 2);
        ck(LG, 0, 2, 1, 0, 0, 1);
        ck(LY, 0, 2, 0, 1, 4, 1);
        ck(LD, 1, 0, 0, 0, 0, 0);

        cur_tag = "long_yellow";
        ck(LR, 0, 1, 0, 0, 0, 1);
        ck(LR, 0, 1, 0, 0, 0, 2);
        ck(LG, 0, 2, 1, 0, 0, 1);
        ck(LG, 0, 2, 0, 0, 0, 2);
        ck(LY, 0, 3, 1, 0, 0, 1);
        for (int i = 2; i <= 8; i++) ck(LY, 0, 3, 0, 0, 0, 8'(i));
        ck(LY, 0, 3, 0, 1, 5, 8);
        ck(LD, 1, 0, 0, 0, 0, 0);

        cur_tag = "cyc_wrap";
        ck(LR, 0, 1, 0, 0, 0, 1);
        for (int n = 0; n < 4; n++) begin
            ck(LR, 0, 1, 0, 0, 0, 2);
            ck(LG, 0, 2, 1, 0, 0, 1);
            ck(LG, 0, 2, 0, 0, 0, 2);
            ck(LY, 0, 3, 1, 0, 0, 1);
            exp_cyc = exp_cyc + 2'd1;
            ck(LR, 0, 1, 1, 0, 0, 1);
        end
        cur_tag = "short_red";
        ck(LG, 0, 1, 0, 1, 4, 1);
        ck(LD, 1, 0, 0, 0, 0, 0);

        cur_tag = "dwell_sat";
        for (int i = 1; i <= 260; i++) begin
            if (i >= 254) ck(LR, 0, 1, 0, 0, 0, (i > 255) ? 8'd255 : 8'(i));
            else st(LR, 0);
        end
        ck(LG, 0, 2, 1, 0, 0, 1);
        ck(LG, 0, 2, 0, 0, 0, 2);
        st(LG, 0);
        st(LG, 0);
        st(LG, 0);

        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_now("reset_mid_green", 17'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_cyc = 2'd0;
        cur_tag = "after_reset";
        ck(LG, 0, 0, 0, 0, 0, 0);
        ck(LG, 0, 0, 0, 0, 0, 0);
        ck(LR, 0, 1, 0, 0, 0, 1);

        for (int k = 0; k < 20 && dueq.size() > 0; k++) @(posedge clk);
        #2;
        if (dueq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d checks still pending, expected 0", dueq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
